// File: rtl/bcd_score_display_if.sv
// Score/brightness inputs and display pin outputs of the two-digit BCD display driver.
// The score source drives the master side; the display driver is the slave.
interface bcd_score_display_if;
    logic       load;
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bright;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       err;

    modport master (
        output load, bcd0, bcd1, bright,
        input  seg, dig, err
    );

    modport slave (
        input  load, bcd0, bcd1, bright,
        output seg, dig, err
    );
endinterface

// File: rtl/bcd_score_display.sv
// Two-digit multiplexed 7-segment driver for the BCD score: shadow capture,
// slot-aligned transfer, ghost-blanking guard, PWM dimming and leading-zero blanking.
module bcd_score_display #(
    parameter int REFRESH_DIV   = 1024,
    parameter int GUARD         = 16,
    parameter int ACTIVE_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                 clk,
    input  logic                 clr,
    bcd_score_display_if.slave   bus
);
    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
    localparam logic [6:0]    SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0]    DIG_OFF    = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic [1:0] {GUARD0, SHOW0, GUARD1, SHOW1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    phase_q, phase_d;
    logic [3:0]    sh0_q, sh0_d, sh1_q, sh1_d;
    logic [3:0]    disp0_q, disp0_d, disp1_q, disp1_d;
    logic          err_q, err_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    dig_q, dig_d;

    logic       slot_end;
    logic       lit;
    logic [6:0] seg_hi;
    logic [1:0] dig_hi;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h40;
        endcase
    endfunction

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= GUARD0;
            cnt_q   <= '0;
            phase_q <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            disp0_q <= '0;
            disp1_q <= '0;
            err_q   <= 1'b0;
            seg_q   <= SEG_OFF;
            dig_q   <= DIG_OFF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            disp0_q <= disp0_d;
            disp1_q <= disp1_d;
            err_q   <= err_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        state_d  = state_q;
        cnt_d    = slot_end ? '0 : cnt_q + CW'(1);
        phase_d  = phase_q + 4'd1;

        case (state_q)
            GUARD0:  if (cnt_q == GUARD_LAST) state_d = SHOW0;
            SHOW0:   if (slot_end)            state_d = GUARD1;
            GUARD1:  if (cnt_q == GUARD_LAST) state_d = SHOW1;
            SHOW1:   if (slot_end)            state_d = GUARD0;
            default:                          state_d = GUARD0;
        endcase

        sh0_d = bus.load ? bus.bcd0 : sh0_q;
        sh1_d = bus.load ? bus.bcd1 : sh1_q;

        // Display registers only move on a slot-start edge; a coincident load bypasses the shadow.
        disp0_d = disp0_q;
        disp1_d = disp1_q;
        if (slot_end) begin
            disp0_d = sh0_d;
            disp1_d = sh1_d;
        end

        err_d = err_q | (bus.load & ((bus.bcd0 > 4'd9) | (bus.bcd1 > 4'd9)));

        lit    = (bus.bright == 4'hF) || (phase_q < bus.bright);
        seg_hi = 7'h00;
        dig_hi = 2'b00;
        if (state_q == SHOW0 && lit) begin
            seg_hi = seg_decode(disp0_q);
            dig_hi = 2'b01;
        end else if (state_q == SHOW1 && lit &&
                     !(BLANK_LEADING != 0 && disp1_q == 4'd0)) begin
            seg_hi = seg_decode(disp1_q);
            dig_hi = 2'b10;
        end

        seg_d = (ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        dig_d = (ACTIVE_LOW != 0) ? ~dig_hi : dig_hi;
    end

    assign bus.seg = seg_q;
    assign bus.dig = dig_q;
    assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_score_display.sv
// Directed bench for bcd_score_display: loads are pushed to a scoreboard with the
// slot edge at which they must become visible, and every sampled cycle is checked.
module tb_bcd_score_display;
    localparam int RD = 32;
    localparam int G  = 4;
    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    typedef struct {
        int         eff;
        logic [3:0] d0;
        logic [3:0] d1;
    } rec_t;

    logic clk = 1'b0;
    logic clr;
    bcd_score_display_if bus ();

    bcd_score_display #(
        .REFRESH_DIV   (RD),
        .GUARD         (G),
        .ACTIVE_LOW    (1),
        .BLANK_LEADING (1)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    rec_t       sb [$];
    int         k;
    logic [3:0] cur0, cur1;
    logic [1:0] last_dig;
    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         fail_cnt = 0;
    int         cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Expected pins produced by the edge that leaves count kk since reset release.
    function automatic logic [8:0] model_out(input int kk, input logic [3:0] u,
                                             input logic [3:0] t, input logic [3:0] br);
        int         c  = kk % RD;
        int         sl = (kk / RD) % 2;
        int         ph = kk % 16;
        bit         on = (br == 4'd15) || (ph < int'(br));
        logic [8:0] r  = {7'h7F, 2'b11};
        if (c >= G && on) begin
            if (sl == 0)        r = {~SEG_TAB[u], 2'b10};
            else if (t != 4'd0) r = {~SEG_TAB[t], 2'b01};
        end
        return r;
    endfunction

    task automatic tick();
        logic [8:0] e;
        e = model_out(k, cur0, cur1, bus.bright);
        @(posedge clk);
        k++;
        while (sb.size() > 0 && sb[0].eff <= k) begin
            cur0 = sb[0].d0;
            cur1 = sb[0].d1;
            void'(sb.pop_front());
        end
        @(negedge clk);
        chk("seg", {25'd0, bus.seg}, {25'd0, e[8:2]});
        chk("dig", {30'd0, bus.dig}, {30'd0, e[1:0]});
        last_dig = bus.dig;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [3:0] d0, input logic [3:0] d1);
        rec_t r;
        int   c;
        c     = k + 1;
        r.d0  = d0;
        r.d1  = d1;
        r.eff = (c % RD == 0) ? c : (c / RD + 1) * RD;
        sb.push_back(r);
        bus.load = 1'b1;
        bus.bcd0 = d0;
        bus.bcd1 = d1;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic model_reset();
        k    = 0;
        cur0 = 4'd0;
        cur1 = 4'd0;
        sb.delete();
    endtask

    initial begin
        clr        = 1'b1;
        bus.load   = 1'b1;
        bus.bcd0   = 4'd9;
        bus.bcd1   = 4'd9;
        bus.bright = 4'd15;
        model_reset();
        #2;
        chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("rst_dig", {30'd0, bus.dig}, 32'h3);
        chk("rst_err", {31'd0, bus.err}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_load_ignored_err", {31'd0, bus.err}, 32'h0);
        bus.load = 1'b0;
        clr      = 1'b0;

        // Out of reset: 0/0 with tens blanked.
        run(2 * RD);

        do_load(4'd2, 4'd4);
        run(2 * 2 * RD);

        do_load(4'd7, 4'd0);
        cnt = 0;
        for (int i = 0; i < 4 * 2 * RD; i++) begin
            tick();
            if (last_dig[1] == 1'b0) cnt++;
        end
        chk("tens_blank_4frames", cnt, 0);

        do_load(4'd0, 4'd1);
        run(2 * 2 * RD);

        while (k % RD != 10) tick();
        do_load(4'hC, 4'd3);
        chk("err_set", {31'd0, bus.err}, 32'h1);
        run(2 * 2 * RD);
        do_load(4'd5, 4'd3);
        run(2 * RD);
        chk("err_sticky", {31'd0, bus.err}, 32'h1);

        bus.bright = 4'd4;
        while (k % (2 * RD) != G) tick();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (last_dig == 2'b10) cnt++;
        end
        chk("bright4_units_16", cnt, 4);

        bus.bright = 4'd0;
        tick();
        cnt = 0;
        for (int i = 0; i < 2 * RD; i++) begin
            tick();
            if (last_dig != 2'b11) cnt++;
        end
        chk("bright0_frame_dark", cnt, 0);

        bus.bright = 4'd15;
        while (k % (2 * RD) != 0) tick();
        cnt = 0;
        for (int i = 0; i < 2 * RD; i++) begin
            tick();
            if (last_dig != 2'b11) cnt++;
        end
        chk("bright15_frame_lit", cnt, 2 * (RD - G));

        // Mid-SHOW0 load lands at the next slot start (SHOW1 after GUARD1).
        while (k % (2 * RD) != 10) tick();
        do_load(4'd5, 4'd5);
        run(2 * 2 * RD);

        // Load on the exact slot-start edge takes the bypass path.
        while (k % RD != RD - 1) tick();
        do_load(4'd9, 4'd8);
        run(2 * RD);
        while (k % RD != RD - 1) tick();
        do_load(4'd6, 4'd0);
        run(2 * RD);

        while (k % (2 * RD) != RD + 12) tick();
        do_load(4'd3, 4'd2);
        while (k % (2 * RD) != RD + 15) tick();
        #2;
        clr = 1'b1;
        #1;
        chk("async_rst_seg", {25'd0, bus.seg}, 32'h7F);
        chk("async_rst_dig", {30'd0, bus.dig}, 32'h3);
        chk("async_rst_err", {31'd0, bus.err}, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        run(2 * 2 * RD);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout k=%0d", k);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bcd_score_display.md
Name: bcd_score_display

Overview:
- Display-side consumer of the two-digit BCD score produced by the BCD counters.
- Captures a units/tens BCD pair on a load strobe and drives a two-digit multiplexed 7-segment display.
- Provides inter-digit ghost-blanking guard time, 4-bit PWM brightness, optional leading-zero blanking and an invalid-digit flag.
- Sits between the score counters and the board's display pins in the PONG top level.

Parameters:
- REFRESH_DIV, 1024: clock cycles per digit slot (guard plus show). Legal range: GUARD+2 or more.
- GUARD, 16: cycles at the start of each slot with both digits disabled. Legal range: 1 or more.
- ACTIVE_LOW, 1: 1 means seg and dig are driven active-low; 0 means active-high.
- BLANK_LEADING, 1: 1 means the tens digit is suppressed when it equals 0.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- load  in  1  capture strobe for bcd0/bcd1.
- bcd0  in  4  units digit.
- bcd1  in  4  tens digit.
- bright  in  4  brightness level, 0 (off) to 15 (full).
- seg  out  7  segments; bit0=a … bit6=g.
- dig  out  2  digit enables; dig[0]=units, dig[1]=tens.
- err  out  1  sticky flag: an invalid digit (>9) was captured.

Behaviour:
- Reset (clr=1, asynchronous):
  - Shadow and display digit registers = 0; state = GUARD0; slot counter = 0; PWM phase = 0; err = 0.
  - seg and dig are all inactive: all 1s when ACTIVE_LOW=1, all 0s otherwise.
  - load is ignored while clr=1.
- Capture:
  - On an edge with load=1, shadow registers take bcd0/bcd1.
  - If several loads occur, the last one before the transfer point wins.
- Transfer:
  - On the edge where a slot begins (entry to GUARD0 or GUARD1), display registers take the shadow values.
  - If load=1 on that same edge, display registers take bcd0/bcd1 directly (bypass).
  - The display never changes mid-slot.
- State machine:
  - States cycle GUARD0 -> SHOW0 -> GUARD1 -> SHOW1 -> GUARD0.
  - The slot counter runs 0..REFRESH_DIV-1 and wraps at the slot end.
  - GUARD state covers counts 0..GUARD-1; SHOW state covers counts GUARD..REFRESH_DIV-1.
  - One frame = 2*REFRESH_DIV cycles.
- PWM:
  - The 4-bit phase free-runs, incrementing every clk.
  - A digit is lit in SHOW when phase < bright, or when bright==15 (always lit).
  - bright==0 means never lit.
  - bright is sampled every cycle; it is not latched.
- Leading-zero blanking: when BLANK_LEADING=1 and the displayed tens digit==0, dig[1] stays inactive for the whole of SHOW1.
- Segment decode (active-high form, then inverted when ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value from A to F shows dash = 40.
- err: set on the edge after a capture whose bcd0 or bcd1 >9. It stays set until clr.
- Outputs:
  - seg and dig are registered, with 1-cycle latency from state/counter.
  - At most one dig bit is active in any cycle; both are never active together.
  - seg reads inactive whenever no digit is lit.
- Reset mid-operation: outputs go inactive immediately. After release, operation restarts at GUARD0 count 0 showing 0/0, subject to blanking.

Test Plan (REFRESH_DIV=32, GUARD=4, ACTIVE_LOW=1, BLANK_LEADING=1):
- Reset: hold clr=1 for 20 ns.
  - Required: seg=7F, dig=11, err=0.
  - After release: dig=11 for the first 5 cycles, then SHOW0 with units 0 gives seg=40 (~3F) and dig=10. Tens is blanked throughout SHOW1.
- Load bcd1=4, bcd0=2, bright=15, then wait for the next slot boundary.
  - Required in SHOW0: seg=24, dig=10 on every cycle.
  - Required in SHOW1: seg=19, dig=01.
  - During guards: dig=11.
- Load bcd1=0, bcd0=7.
  - Required: dig[1] never active across 4 frames; SHOW0 seg=78.
  - Then load bcd1=1, bcd0=0: required SHOW1 seg=79, SHOW0 seg=40.
- Load bcd0=C, bcd1=3.
  - Required: err=1 on the cycle after load; SHOW0 seg=3F (dash); SHOW1 seg=30.
  - err remains 1 after loading 3/5, and returns to 0 only on clr.
- Brightness checks:
  - bright=4: dig=10 active for exactly 4 of every 16 consecutive SHOW0 cycles.
  - bright=0: dig=11 for a full frame.
  - bright=15: active on every SHOW cycle.
- Load timing and mid-operation reset:
  - Load 5/5 mid-SHOW0: required, the value appears only from the SHOW1 after GUARD1.
  - Load on the exact boundary edge: required, visible in the immediately following SHOW.
  - Assert clr mid-SHOW1: required, seg=7F and dig=11 asynchronously; after release, restart from GUARD0 showing 0.
